// File: rtl/spi_adc_sampler_pkg.sv
// spi_adc_pkg: FSM state encoding plus channel-index and counter width helpers for spi_adc_sampler
package spi_adc_pkg;
  typedef enum logic [2:0] {IDLE, CONVERT, SETUP, SHIFT, DONE} state_t;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/spi_adc_sampler_clk_div.sv
// spi_clk_div: SCK generator, half-period tick every CLK_DIV enabled cycles; ports clk, reset, i_clr (restart at phase 0), i_en, o_rise/o_fall (tick that drives sck up/down), o_sck
module spi_clk_div
  import spi_adc_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall,
  output logic o_sck
);
  localparam int CW = cnt_w(CLK_DIV);
  logic [CW-1:0] r_cnt;
  logic r_sck;
  logic w_tick;
  assign w_tick = i_en && r_cnt == CW'(CLK_DIV - 1);
  assign o_rise = w_tick && !r_sck;
  assign o_fall = w_tick && r_sck;
  assign o_sck = r_sck;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (i_en) begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      r_sck <= w_tick ? !r_sck : r_sck;
    end
endmodule

// File: rtl/spi_adc_sampler.sv
// spi_adc_sampler: CNV pulse, conversion wait, then MSB-first SPI readout of one of NUM_CH ADCs, single-shot or round-robin; ports clk, reset, start/ch_sel/continuous in, busy/overrun/cnv/cs_n/sck out, miso in, data/data_ch/data_valid out
module spi_adc_sampler
  import spi_adc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 4,
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ch_w(NUM_CH)-1:0]   ch_sel,
  input  logic                      continuous,
  output logic                      busy,
  output logic                      overrun,
  output logic                      cnv,
  output logic [NUM_CH-1:0]         cs_n,
  output logic                      sck,
  input  logic                      miso,
  output logic [DATA_W-1:0]         data,
  output logic [ch_w(NUM_CH)-1:0]   data_ch,
  output logic                      data_valid
);
  localparam int CH_W = ch_w(NUM_CH);
  localparam int CV_W = cnt_w(CONV_CYCLES);
  localparam int BT_W = cnt_w(DATA_W);
  state_t r_state;
  logic [CH_W-1:0] r_ch;
  logic [CV_W-1:0] r_conv;
  logic [BT_W-1:0] r_bits;
  logic [DATA_W-1:0] r_sh;
  logic w_rise, w_fall, w_clr, w_en, w_last;
  logic [CH_W-1:0] w_ch_start, w_ch_next;
  assign w_clr = r_state == CONVERT && r_conv == CV_W'(CONV_CYCLES - 1);
  assign w_last = r_bits == BT_W'(DATA_W);
  // divider stops once the final fall is counted so it cannot start another bit
  assign w_en = r_state == SETUP || (r_state == SHIFT && !w_last);
  assign busy = r_state != IDLE;
  assign w_ch_start = (int'(ch_sel) < NUM_CH) ? ch_sel : '0;
  assign w_ch_next = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (w_en),
    .o_rise(w_rise),
    .o_fall(w_fall),
    .o_sck (sck)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_conv     <= '0;
      r_bits     <= '0;
      r_sh       <= '0;
      cnv        <= 1'b0;
      cs_n       <= '1;
      overrun    <= 1'b0;
      data       <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      overrun    <= start && r_state != IDLE;
      if (w_rise) r_sh <= {r_sh[DATA_W-2:0], miso};
      if (w_fall) r_bits <= r_bits + BT_W'(1);
      case (r_state)
        IDLE:
          if (start || continuous) begin
            r_ch    <= w_ch_start;
            r_conv  <= '0;
            cnv     <= 1'b1;
            r_state <= CONVERT;
          end
        CONVERT:
          if (w_clr) begin
            cnv     <= 1'b0;
            cs_n    <= ~(NUM_CH'(1) << r_ch);
            r_bits  <= '0;
            r_state <= SETUP;
          end else r_conv <= r_conv + CV_W'(1);
        SETUP:
          if (w_rise) r_state <= SHIFT;
        SHIFT:
          if (w_last) begin
            cs_n       <= '1;
            data       <= r_sh;
            data_ch    <= r_ch;
            data_valid <= 1'b1;
            r_state    <= DONE;
          end
        DONE: begin
          r_state <= continuous ? CONVERT : IDLE;
          if (continuous) begin
            r_ch   <= w_ch_next;
            r_conv <= '0;
            cnv    <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_adc_sampler.sv
// tb_spi_adc_sampler: directed scoreboard bench for spi_adc_sampler, 4-ch/16-bit and 1-ch/24-bit instances
module tb_spi_adc_sampler;
  logic clk = 1'b0, reset, start, continuous, start2;
  logic [1:0] ch_sel;
  logic ch_sel2;
  logic busy, overrun, cnv, sck, miso, data_valid;
  logic [3:0] cs_n;
  logic [15:0] data;
  logic [1:0] data_ch;
  logic busy2, overrun2, cnv2, sck2, miso2, data_valid2;
  logic [0:0] cs_n2;
  logic [23:0] data2;
  logic data_ch2;
  always #5 clk = ~clk;

  spi_adc_sampler dut (
    .clk(clk), .reset(reset), .start(start), .ch_sel(ch_sel), .continuous(continuous),
    .busy(busy), .overrun(overrun), .cnv(cnv), .cs_n(cs_n), .sck(sck), .miso(miso),
    .data(data), .data_ch(data_ch), .data_valid(data_valid)
  );
  spi_adc_sampler #(.DATA_W(24), .NUM_CH(1), .CLK_DIV(1), .CONV_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .ch_sel(ch_sel2), .continuous(1'b0),
    .busy(busy2), .overrun(overrun2), .cnv(cnv2), .cs_n(cs_n2), .sck(sck2), .miso(miso2),
    .data(data2), .data_ch(data_ch2), .data_valid(data_valid2)
  );

  // ADC models: advance one bit on each sck fall, restart when deselected
  logic [15:0] words [4];
  logic [15:0] cur_word;
  logic [23:0] pat2 = 24'hAAAAAA;
  int idx = 0, idx2 = 0;
  logic cs_idle, cs_idle2;
  assign cs_idle = &cs_n;
  assign cs_idle2 = cs_n2[0];
  always_comb begin
    cur_word = 16'h0;
    for (int i = 0; i < 4; i++) if (!cs_n[i]) cur_word = words[i];
  end
  always @(negedge sck or posedge cs_idle) if (cs_idle) idx = 0; else idx++;
  always @(negedge sck2 or posedge cs_idle2) if (cs_idle2) idx2 = 0; else idx2++;
  assign miso = (!cs_idle && idx < 16) ? cur_word[15-idx] : 1'b0;
  assign miso2 = (!cs_idle2 && idx2 < 24) ? pat2[23-idx2] : 1'b0;

  int vectors = 0, miscompares = 0;
  int t = 0, rises = 0, run = 0, cnv_runs = 0, cnv_bad = 0, cs_bad = 0;
  int dvs = 0, dv_t = 0, dv_gap = 0, dvs2 = 0, dv2_t = 0;
  logic p_sck = 1'b0, p_cnv = 1'b0;
  logic [3:0] cs_and = 4'hF;
  logic [17:0] q [$];
  logic [24:0] q2 [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
    if (sck && !p_sck) rises++;
    if (cnv) run++;
    else begin
      if (p_cnv) begin
        cnv_runs++;
        if (run != 100) cnv_bad++;
      end
      run = 0;
    end
    if ($countones(~cs_n) > 1 || (cnv && !cs_idle)) cs_bad++;
    cs_and &= cs_n;
    if (data_valid) begin
      dvs++;
      dv_gap = t - dv_t;
      dv_t = t;
      if (q.size() == 0) check("dv_unexpected", {data_ch, data}, 18'h0);
      else check("dv_word", {data_ch, data}, q.pop_front());
    end
    if (data_valid2) begin
      dvs2++;
      dv2_t = t;
      if (q2.size() == 0) check("dv2_unexpected", {data_ch2, data2}, 25'h0);
      else check("dv2_word", {data_ch2, data2}, q2.pop_front());
    end
    p_sck = sck;
    p_cnv = cnv;
  endtask

  task automatic wait_dv(input string tag, input int budget);
    int c = dvs;
    int k = 0;
    while (dvs == c && k < budget) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, 64'(dvs != c), 64'd1);
  endtask

  initial begin
    int tz, cr, dz;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; ch_sel = 2'd0; start2 = 1'b0; ch_sel2 = 1'b0;
    for (int i = 0; i < 4; i++) words[i] = 16'h0;
    repeat (3) step();
    check("reset_state", {cs_n, sck, cnv, busy, overrun, data, data_ch, data_valid, cs_n2, sck2, cnv2, busy2},
          {4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    step();
    // reset at the 8th sck rise
    words[0] = 16'h1234;
    start = 1'b1;
    step();
    start = 1'b0;
    rises = 0;
    for (int k = 0; k < 400 && rises < 8; k++) step();
    check("rise8_reached", 64'(rises), 64'd8);
    reset = 1'b1;
    #1;
    check("async_reset_out", {cs_n, sck, cnv, busy}, {4'hF, 1'b0, 1'b0, 1'b0});
    check("reset_data_zero", {data, data_ch}, 18'h0);
    repeat (2) step();
    reset = 1'b0;
    step();
    check("no_partial_publish", 64'(dvs), 64'd0);
    q.push_back({2'd0, 16'h1234});
    start = 1'b1;
    step();
    start = 1'b0;
    wait_dv("after_reset", 300);
    step();
    // single shot on channel 2
    words[2] = 16'hA5C3;
    ch_sel = 2'd2;
    q.push_back({2'd2, 16'hA5C3});
    start = 1'b1;
    tz = t;
    rises = 0; cs_bad = 0; cs_and = 4'hF; cnv_bad = 0;
    step();
    start = 1'b0;
    check("idle_start_no_overrun", 64'(overrun), 64'd0);
    wait_dv("single", 400);
    check("single_latency", 64'(dv_t - tz), 64'd166);
    check("single_rises", 64'(rises), 64'd16);
    check("single_cs_pattern", 64'(cs_and), 64'hB);
    step();
    check("single_after", {data_valid, busy, data}, {1'b0, 1'b0, 16'hA5C3});
    check("single_cs_cnv", 64'(cs_bad + cnv_bad), 64'd0);
    // continuous scan from channel 3
    for (int i = 0; i < 4; i++) words[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 5; i++) q.push_back({2'((3 + i) % 4), 16'h1000 + 16'((3 + i) % 4)});
    cnv_runs = 0; cnv_bad = 0; cs_bad = 0;
    ch_sel = 2'd3;
    continuous = 1'b1;
    step();
    wait_dv("scan0", 400);
    ch_sel = 2'd1;
    for (int i = 1; i < 5; i++) wait_dv("scan", 400);
    continuous = 1'b0;
    check("scan_period", 64'(dv_gap), 64'd166);
    step();
    check("scan_stop_busy", 64'(busy), 64'd0);
    check("scan_cnv_runs", 64'(cnv_runs), 64'd5);
    check("scan_cnv_len_cs", 64'(cnv_bad + cs_bad), 64'd0);
    // start during SHIFT
    words[1] = 16'hBEEF;
    q.push_back({2'd1, 16'hBEEF});
    ch_sel = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (120) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("overrun_pulse", 64'(overrun), 64'd1);
    step();
    check("overrun_one_cycle", 64'(overrun), 64'd0);
    cr = cnv_runs;
    dz = dvs;
    wait_dv("overrun_word", 100);
    repeat (200) step();
    check("overrun_no_second", {32'(cnv_runs - cr), 32'(dvs - dz)}, {32'd0, 32'd1});
    // continuous dropped mid-word
    q.push_back({2'd0, 16'h1000});
    ch_sel = 2'd0;
    continuous = 1'b1;
    step();
    repeat (130) step();
    continuous = 1'b0;
    wait_dv("drop", 100);
    step();
    check("drop_busy", 64'(busy), 64'd0);
    cr = cnv_runs;
    dz = dvs;
    repeat (200) step();
    check("drop_no_more", {32'(cnv_runs - cr), 32'(dvs - dz), 1'b0}, {32'd0, 32'd0, cnv});
    // 24-bit, divide-by-1, one-cycle conversion, single channel
    q2.push_back({1'b0, 24'hAAAAAA});
    ch_sel2 = 1'b1;
    start2 = 1'b1;
    tz = t;
    dz = dvs2;
    step();
    start2 = 1'b0;
    for (int k = 0; k < 100 && dvs2 == dz; k++) step();
    check("w24_seen", 64'(dvs2 - dz), 64'd1);
    check("w24_latency", 64'(dv2_t - tz), 64'd51);
    step();
    check("w24_idle", {busy2, cs_n2, sck2}, {1'b0, 1'b1, 1'b0});
    check("queues_drained", 64'(q.size() + q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
